// File: rtl/common.sv
// Shared types for the two-core snooping coherence bus.
// req_type_t  : kind of request a core has pending on the bus
// bus_state_t : bus controller FSM state
// blk_state_t : per-line cache state used by the attached caches
package common;

  typedef enum logic [1:0] {
    REQ_NONE    = 2'd0,
    REQ_RD_MISS = 2'd1,
    REQ_WR_MISS = 2'd2,
    REQ_UPGRADE = 2'd3
  } req_type_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SNOOP = 3'd1,
    ST_WB    = 3'd2,
    ST_MEM   = 3'd3,
    ST_RESP  = 3'd4
  } bus_state_t;

  typedef enum logic [1:0] {
    BLK_INVALID  = 2'd0,
    BLK_SHARED   = 2'd1,
    BLK_MODIFIED = 2'd2
  } blk_state_t;

  // Several pulses in one cycle from the same core collapse to the
  // strongest request: write miss, then upgrade, then read miss.
  function automatic req_type_t decode_req(input logic wm, input logic inv, input logic rm);
    if (wm) return REQ_WR_MISS;
    if (inv) return REQ_UPGRADE;
    if (rm) return REQ_RD_MISS;
    return REQ_NONE;
  endfunction

endpackage

// File: rtl/coherence_bus_if.sv
// Signal bundle between the coherence bus, the two cache controllers and
// the shared memory.
// master : the bus controller (drives snoop, memory and fill signals)
// slave  : the environment (caches + memory)
interface coherence_bus_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
);
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0]             read_miss;
  logic [1:0]             write_miss;
  logic [1:0]             invalidate;
  logic [1:0]             snoop_search;
  logic [ADDR_W-3:0]      snoop_boci;
  logic [1:0]             snoop_found;
  logic [1:0]             snoop_dirty;
  logic [1:0][DATA_W-1:0] snoop_data;
  logic [1:0]             snoop_inval;
  logic [1:0]             snoop_downgrade;
  logic [ADDR_W-1:0]      mem_addr;
  logic                   mem_re;
  logic                   mem_we;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;
  logic                   mem_rdy;
  logic [1:0]             fill_valid;
  logic [DATA_W-1:0]      fill_data;
  logic                   busy;

  modport master (
    input  req_addr, read_miss, write_miss, invalidate,
           snoop_found, snoop_dirty, snoop_data, mem_rdata, mem_rdy,
    output snoop_search, snoop_boci, snoop_inval, snoop_downgrade,
           mem_addr, mem_re, mem_we, mem_wdata, fill_valid, fill_data, busy
  );

  modport slave (
    output req_addr, read_miss, write_miss, invalidate,
           snoop_found, snoop_dirty, snoop_data, mem_rdata, mem_rdy,
    input  snoop_search, snoop_boci, snoop_inval, snoop_downgrade,
           mem_addr, mem_re, mem_we, mem_wdata, fill_valid, fill_data, busy
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
// req       : pending request per core
// advance   : the grant is being taken this cycle
// gnt       : index of the winning core
// gnt_valid : at least one request pending
// The priority pointer only moves when both cores compete, so a lone
// request never costs the other core its turn at the next contention.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt,
  output logic       gnt_valid
);
  logic last_q, last_d;

  always_comb begin
    gnt_valid = |req;
    gnt       = 1'b0;
    case (req)
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_q;
      default: gnt = 1'b0;
    endcase
    last_d = last_q;
    if (advance && req == 2'b11) last_d = gnt;
  end

  // Core 1 counts as last winner out of reset so core 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
endmodule

// File: rtl/coherence_bus.sv
// Snooping coherence bus for two cores: one pending request per core,
// round-robin grant, snoop of the other core, optional write-back or
// memory read, then a one-cycle fill response to the requester.
// clk, rst_n : system clock, async active-low reset
// bus        : master side of coherence_bus_if (cores, snoop, memory)
//
// state    | meaning
// IDLE     | waiting for any pending request
// SNOOP    | search strobe to the other core, sample its answer
// WB       | write snooped dirty word to memory until mem_rdy
// MEM      | read memory until mem_rdy, capture mem_rdata
// RESP     | fill_valid to requester, clear its pending entry
module coherence_bus
  import common::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  coherence_bus_if.master bus
);
  bus_state_t             state_q, state_d;
  req_type_t              pend_type_q [2];
  req_type_t              pend_type_d [2];
  req_type_t              pulse_type  [2];
  logic [1:0][ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic                   grant_q, grant_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [1:0]             inval_q, inval_d, dgrade_q, dgrade_d;
  logic [1:0]             pend_vld;
  logic                   arb_gnt, arb_vld, arb_adv;
  logic                   other;
  req_type_t              cur_type;
  logic [ADDR_W-1:0]      cur_addr;

  assign pulse_type[0] = decode_req(bus.write_miss[0], bus.invalidate[0], bus.read_miss[0]);
  assign pulse_type[1] = decode_req(bus.write_miss[1], bus.invalidate[1], bus.read_miss[1]);
  assign pend_vld = {pend_type_q[1] != REQ_NONE, pend_type_q[0] != REQ_NONE};
  assign other    = ~grant_q;
  assign cur_type = pend_type_q[grant_q];
  assign cur_addr = pend_addr_q[grant_q];

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (pend_vld),
    .advance   (arb_adv),
    .gnt       (arb_gnt),
    .gnt_valid (arb_vld)
  );

  // A core already pending ignores new pulses; the granted core's entry
  // stays valid until RESP so its pulses are dropped for the whole service.
  always_comb begin
    pend_type_d = pend_type_q;
    pend_addr_d = pend_addr_q;
    for (int i = 0; i < 2; i++) begin
      if (state_q == ST_RESP && grant_q == 1'(i)) pend_type_d[i] = REQ_NONE;
      if (pend_type_q[i] == REQ_NONE && pulse_type[i] != REQ_NONE) begin
        pend_type_d[i] = pulse_type[i];
        pend_addr_d[i] = bus.req_addr[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    data_d   = data_q;
    inval_d  = '0;
    dgrade_d = '0;
    arb_adv  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          arb_adv = 1'b1;
          grant_d = arb_gnt;
          state_d = ST_SNOOP;
        end
      end
      ST_SNOOP: begin
        if (cur_type == REQ_UPGRADE) begin
          inval_d[other] = bus.snoop_found[other];
          state_d        = ST_RESP;
        end else if (bus.snoop_found[other]) begin
          if (cur_type == REQ_WR_MISS) inval_d[other]  = 1'b1;
          else                         dgrade_d[other] = 1'b1;
          data_d  = bus.snoop_data[other];
          state_d = bus.snoop_dirty[other] ? ST_WB : ST_RESP;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        if (bus.mem_rdy) state_d = ST_RESP;
      end
      ST_MEM: begin
        if (bus.mem_rdy) begin
          data_d  = bus.mem_rdata;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pend_type_q <= '{REQ_NONE, REQ_NONE};
      pend_addr_q <= '0;
      grant_q     <= 1'b0;
      data_q      <= '0;
      inval_q     <= '0;
      dgrade_q    <= '0;
    end else begin
      state_q     <= state_d;
      pend_type_q <= pend_type_d;
      pend_addr_q <= pend_addr_d;
      grant_q     <= grant_d;
      data_q      <= data_d;
      inval_q     <= inval_d;
      dgrade_q    <= dgrade_d;
    end
  end

  // Memory strobes decode straight from state so reset drops them at once.
  assign bus.busy            = state_q != ST_IDLE;
  assign bus.snoop_search    = (state_q == ST_SNOOP) ? (grant_q ? 2'b01 : 2'b10) : 2'b00;
  assign bus.snoop_boci      = bus.busy ? cur_addr[ADDR_W-1:2] : '0;
  assign bus.snoop_inval     = inval_q;
  assign bus.snoop_downgrade = dgrade_q;
  assign bus.mem_re          = state_q == ST_MEM;
  assign bus.mem_we          = state_q == ST_WB;
  assign bus.mem_addr        = (state_q == ST_MEM || state_q == ST_WB) ? cur_addr : '0;
  assign bus.mem_wdata       = (state_q == ST_WB) ? data_q : '0;
  assign bus.fill_valid      = (state_q == ST_RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.fill_data       = data_q;
endmodule

// File: doc/coherence_bus.md
COHERENCE_BUS -- requirements
Module: coherence_bus

Interface
REQ-001 Parameter ADDR_W, default 13: word address width; block address is ADDR_W-2 bits.
REQ-002 Parameter DATA_W, default 16: data word width.
REQ-003 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_addr  input  [1:0][12:0]  per-core word address of the missing access.
REQ-007 read_miss  input  [1:0]  per-core one-cycle read-miss pulse from cache controller.
REQ-008 write_miss  input  [1:0]  per-core one-cycle write-miss pulse.
REQ-009 invalidate  input  [1:0]  per-core one-cycle upgrade (SHARED->MODIFIED) pulse.
REQ-010 snoop_search  output  [1:0]  per-core search strobe, drives that core's cpu_search.
REQ-011 snoop_boci  output  11  snooped block address, req_addr[12:2] of granted request.
REQ-012 snoop_found  input  [1:0]  per-core snoop hit (valid line), combinational from cache.
REQ-013 snoop_dirty  input  [1:0]  per-core snooped line is MODIFIED.
REQ-014 snoop_data  input  [1:0][15:0]  per-core snooped word.
REQ-015 snoop_inval  output  [1:0]  one-cycle pulse: set snooped line INVALID.
REQ-016 snoop_downgrade  output  [1:0]  one-cycle pulse: set snooped line SHARED.
REQ-017 mem_addr  output  13; mem_re  output  1; mem_we  output  1; mem_wdata  output  16: memory request.
REQ-018 mem_rdata  input  16; mem_rdy  input  1: memory completion, one-cycle pulse.
REQ-019 fill_valid  output  [1:0]  one-cycle per-core completion pulse; fill_data  output  16  fill word.
REQ-020 busy  output  1  high whenever FSM not IDLE.

Function
REQ-021 Each core SHALL have one pending register (type, address) set on any miss/invalidate pulse; pulses from a core already pending SHALL be ignored.
REQ-022 Priority within a pulse: write_miss > invalidate > read_miss.
REQ-023 Arbitration SHALL be round-robin; simultaneous pending requests grant the core not granted last; after reset core 0 wins.
REQ-024 States: IDLE, SNOOP, WB, MEM, RESP.
REQ-025 IDLE -> SNOOP one cycle after any pending bit set; grant and address latched on that edge.
REQ-026 SNOOP (exactly one cycle): snoop_search asserted to the non-granted core only; snoop_found/dirty/data sampled at end of cycle.
REQ-027 Read miss, found and dirty: pulse snoop_downgrade, go WB (mem_we=1, mem_wdata=snooped word) until mem_rdy, then RESP with snooped word.
REQ-028 Read miss, found and clean: pulse snoop_downgrade, go RESP with snooped word, no memory access.
REQ-029 Write miss, found: pulse snoop_inval; dirty -> WB then RESP with snooped word; clean -> RESP with snooped word.
REQ-030 Read or write miss, not found: MEM with mem_re=1 held until mem_rdy; mem_rdata captured; then RESP.
REQ-031 Invalidate: pulse snoop_inval if found, then RESP; fill_data undefined-but-held (previous value).
REQ-032 RESP (one cycle): fill_valid[grant]=1, fill_data driven, pending[grant] cleared; next state IDLE.
REQ-033 mem_re and mem_we SHALL never be high together; mem_addr = latched req_addr while in WB/MEM.
REQ-034 Minimum latency pulse-to-fill_valid: 3 cycles (cache-to-cache clean hit).
REQ-035 A pulse arriving from the non-granted core during any state SHALL be captured without loss.
REQ-036 mem_rdy outside WB/MEM SHALL be ignored.

Reset
REQ-037 On rst_n low: state IDLE, pending cleared, last-grant = core 1, all outputs 0, fill_data 0.
REQ-038 Reset mid-transaction SHALL abort it with no fill_valid and no memory strobe on the following cycle.

Structure
REQ-039 Request-type enum (NONE, RD_MISS, WR_MISS, UPGRADE) and bus state enum SHALL live in package common alongside blk_state_t.
REQ-040 One sub-module, rr_arbiter2 (2-way round-robin), is natural; FSM stays in coherence_bus.

Verification
REQ-041 Core0 read_miss addr 0x0104, no snoop hit, mem_rdata 0xBEEF after 4 cycles -> fill_valid[0], fill_data 0xBEEF, mem_re held 4 cycles.
REQ-042 Core1 read_miss, core0 snoop_found=1 dirty=1 data 0x1234 -> snoop_downgrade[0], mem_we with 0x1234, fill_data 0x1234 to core1.
REQ-043 Core0 write_miss, core1 found clean -> snoop_inval[1] one cycle, fill_valid[0] 3 cycles after pulse, no memory access.
REQ-044 Both cores read_miss same cycle after reset -> core0 served first, core1 second; repeat -> core1 first.
REQ-045 Core0 invalidate with core1 not found -> no snoop_inval, fill_valid[0] in RESP.
REQ-046 rst_n low while in MEM -> mem_re 0, pending cleared, no fill_valid after release.
